// File: rtl/reg_seq_pkg.sv
// Shared types, field positions and helpers for the register-file sequencer.
package reg_seq_pkg;

  localparam int unsigned NREGS = 32'd16;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned DW    = 32'd8;
  localparam int unsigned IW    = 32'd16;

  localparam int unsigned OPC_HI = 32'd15;
  localparam int unsigned OPC_LO = 32'd12;
  localparam int unsigned RD_HI  = 32'd11;
  localparam int unsigned RD_LO  = 32'd8;
  localparam int unsigned RS1_HI = 32'd7;
  localparam int unsigned RS1_LO = 32'd4;
  localparam int unsigned RS2_HI = 32'd3;
  localparam int unsigned RS2_LO = 32'd0;
  localparam int unsigned IMM_HI = 32'd7;
  localparam int unsigned IMM_LO = 32'd0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_LDI  = 4'd5,
    OP_MOV  = 4'd6,
    OP_NOP  = 4'd7,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_A = 3'd5,
    ALU_PASS_B = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  // Only ADD..MOV produce a register-file result.
  function automatic logic writes_rd(input logic [3:0] opcode);
    return (opcode < 4'd7);
  endfunction

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Instruction handshake and register-file/ALU control bundle.
// retired[15:0] is present only when REG_SEQ_PERF_EN is defined.
interface reg_seq_ctrl_if;
  import reg_seq_pkg::*;

  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] RA1;
  logic [AW-1:0] RA2;
  logic [AW-1:0] WA;
  logic          write_enable;
  logic [2:0]    alu_op;
  logic [DW-1:0] imm;
  logic          imm_sel;
  logic          illegal;
  logic          halted;
`ifdef REG_SEQ_PERF_EN
  logic [15:0]   retired;
`endif

  modport slave (
    input  instr, instr_valid,
    output instr_ready, RA1, RA2, WA, write_enable, alu_op, imm, imm_sel,
           illegal, halted
`ifdef REG_SEQ_PERF_EN
    , output retired
`endif
  );

  modport master (
    output instr, instr_valid,
    input  instr_ready, RA1, RA2, WA, write_enable, alu_op, imm, imm_sel,
           illegal, halted
`ifdef REG_SEQ_PERF_EN
    , input retired
`endif
  );

endinterface

// File: rtl/reg_seq_decode.sv
// Combinational opcode decoder: ALU select, operand-B source and instruction class.
module reg_seq_decode
  import reg_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output alu_op_e    alu_op_o,
  output logic       imm_sel_o,
  output logic       writes_o,
  output logic       illegal_o,
  output logic       is_halt_o
);

  // Map opcode to ALU controls; undefined opcodes fall through as NOPs.
  always_comb begin
    alu_op_o  = ALU_ADD;
    imm_sel_o = 1'b0;
    illegal_o = 1'b0;
    is_halt_o = 1'b0;
    writes_o  = writes_rd(opcode_i);
    case (opcode_i)
      OP_ADD:  alu_op_o = ALU_ADD;
      OP_SUB:  alu_op_o = ALU_SUB;
      OP_AND:  alu_op_o = ALU_AND;
      OP_OR:   alu_op_o = ALU_OR;
      OP_XOR:  alu_op_o = ALU_XOR;
      OP_LDI: begin
        alu_op_o  = ALU_PASS_B;
        imm_sel_o = 1'b1;
      end
      OP_MOV:  alu_op_o  = ALU_PASS_A;
      OP_NOP:  alu_op_o  = ALU_ADD;
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Four-cycle sequencer driving register-file addresses, ALU op and write strobe.
// Optional retired-instruction counter enabled by REG_SEQ_PERF_EN.
module reg_seq_ctrl
  import reg_seq_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  reg_seq_ctrl_if.slave seq
);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] ra1_q, ra1_d;
  logic [AW-1:0] ra2_q, ra2_d;
  logic [AW-1:0] wa_q, wa_d;
  alu_op_e       alu_op_q, alu_op_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          imm_sel_q, imm_sel_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic          illegal_q, illegal_d;
  logic          halted_q, halted_d;

  alu_op_e       dec_alu_op;
  logic          dec_imm_sel;
  logic          dec_writes;
  logic          dec_illegal;
  logic          dec_is_halt;

  reg_seq_decode u_decode (
    .opcode_i  (instr_q[OPC_HI:OPC_LO]),
    .alu_op_o  (dec_alu_op),
    .imm_sel_o (dec_imm_sel),
    .writes_o  (dec_writes),
    .illegal_o (dec_illegal),
    .is_halt_o (dec_is_halt)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    ra1_d     = ra1_q;
    ra2_d     = ra2_q;
    wa_d      = wa_q;
    alu_op_d  = alu_op_q;
    imm_d     = imm_q;
    imm_sel_d = imm_sel_q;
    illegal_d = illegal_q;
    we_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seq.instr_valid && ready_q) begin
          instr_d = seq.instr;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        ra1_d     = instr_q[RS1_HI:RS1_LO];
        ra2_d     = instr_q[RS2_HI:RS2_LO];
        wa_d      = instr_q[RD_HI:RD_LO];
        imm_d     = instr_q[IMM_HI:IMM_LO];
        alu_op_d  = dec_alu_op;
        imm_sel_d = dec_imm_sel;
        illegal_d = illegal_q | dec_illegal;
        state_d   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        // r0 is hardwired zero, so a write to it is suppressed entirely.
        we_d    = dec_writes && (instr_q[RD_HI:RD_LO] != {AW{1'b0}});
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (dec_is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    ready_d  = (state_d == ST_IDLE);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      instr_q   <= {IW{1'b0}};
      ra1_q     <= {AW{1'b0}};
      ra2_q     <= {AW{1'b0}};
      wa_q      <= {AW{1'b0}};
      alu_op_q  <= ALU_ADD;
      imm_q     <= {DW{1'b0}};
      imm_sel_q <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ra1_q     <= ra1_d;
      ra2_q     <= ra2_d;
      wa_q      <= wa_d;
      alu_op_q  <= alu_op_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

`ifdef REG_SEQ_PERF_EN
  logic [15:0] retired_q, retired_d;

  // Every WRITEBACK retires one instruction, whatever its class.
  always_comb begin
    if (state_q == ST_WRITEBACK) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      retired_q <= 16'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign seq.retired = retired_q;
`endif

  assign seq.instr_ready  = ready_q;
  assign seq.RA1          = ra1_q;
  assign seq.RA2          = ra2_q;
  assign seq.WA           = wa_q;
  assign seq.write_enable = we_q;
  assign seq.alu_op       = alu_op_q;
  assign seq.imm          = imm_q;
  assign seq.imm_sel      = imm_sel_q;
  assign seq.illegal      = illegal_q;
  assign seq.halted       = halted_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed-vector bench for reg_seq_ctrl with a small register-file/ALU model.
module tb_reg_seq_ctrl;

  logic clk;
  logic nrst;
  int   n_vec;
  int   n_fail;
  int   write_count;
  logic [7:0] regs [16] = '{default: 8'h00};

  reg_seq_ctrl_if bus ();

  reg_seq_ctrl dut (
    .CLK  (clk),
    .nRST (nrst),
    .seq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: register file with r0 hardwired zero, ALU on RA1/RA2/imm.
  always @(posedge clk) begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    if (bus.write_enable === 1'b1) begin
      a = (bus.RA1 == 4'd0) ? 8'h00 : regs[bus.RA1];
      b = bus.imm_sel ? bus.imm : ((bus.RA2 == 4'd0) ? 8'h00 : regs[bus.RA2]);
      case (bus.alu_op)
        3'd0:    r = a + b;
        3'd1:    r = a - b;
        3'd2:    r = a & b;
        3'd3:    r = a | b;
        3'd4:    r = a ^ b;
        3'd5:    r = a;
        3'd6:    r = b;
        default: r = 8'h00;
      endcase
      if (bus.WA != 4'd0) regs[bus.WA] <= r;
      write_count <= write_count + 1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and run it to completion (four cycles).
  task automatic exec(input logic [15:0] ins, input int exp_we, input string tag);
    int wc0;
    int k;
    k = 0;
    while (bus.instr_ready !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    check_vec({tag, "_rdy"}, {31'd0, bus.instr_ready}, 32'd1);
    wc0 = write_count;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    repeat (4) step();
    check_vec({tag, "_we"}, write_count - wc0, exp_we);
    check_vec({tag, "_idle"}, {31'd0, bus.instr_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc0;
    int hi_cnt;
    logic [15:0] ret0;
    n_vec = 0;
    n_fail = 0;
    write_count = 0;
    ret0 = 16'd0;
    nrst = 1'b0;
    bus.instr = 16'h0000;
    bus.instr_valid = 1'b0;
    repeat (3) step();

    check_vec("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    check_vec("rst_ctrl", {bus.RA1, bus.RA2, bus.WA, bus.alu_op, bus.imm}, 32'd0);
    check_vec("rst_flags", {bus.write_enable, bus.imm_sel, bus.illegal, bus.halted}, 32'd0);
`ifdef REG_SEQ_PERF_EN
    check_vec("rst_retired", bus.retired, 32'd0);
`endif
    nrst = 1'b1;
    step();
    check_vec("ready_after_rst", {31'd0, bus.instr_ready}, 32'd1);

    // LDI r3,0x5A with cycle-by-cycle timing
    bus.instr = 16'h535A;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    check_vec("ldi_c1_ready", {31'd0, bus.instr_ready}, 32'd0);
    check_vec("ldi_c1_we", {31'd0, bus.write_enable}, 32'd0);
    step();
    check_vec("ldi_c2_we", {31'd0, bus.write_enable}, 32'd0);
    check_vec("ldi_c2_ctrl", {bus.WA, bus.imm, bus.imm_sel, bus.alu_op}, {16'd0, 4'd3, 8'h5A, 1'b1, 3'd6});
    step();
    check_vec("ldi_c3_we", {31'd0, bus.write_enable}, 32'd1);
    check_vec("ldi_c3_ready", {31'd0, bus.instr_ready}, 32'd0);
    step();
    check_vec("ldi_c4_we", {31'd0, bus.write_enable}, 32'd0);
    check_vec("ldi_c4_ready", {31'd0, bus.instr_ready}, 32'd1);
    check_vec("ldi_r3", regs[3], 32'h5A);

    // LDI r1; LDI r2; ADD r15,r1,r2
    exec(16'h510F, 1, "ldi_r1");
    exec(16'h52F0, 1, "ldi_r2");
    exec(16'h0F12, 1, "add_r15");
    check_vec("add_ctrl", {bus.RA1, bus.RA2, bus.WA, bus.alu_op, bus.imm_sel}, {12'd0, 4'd1, 4'd2, 4'd15, 3'd0, 1'b0});
    check_vec("cpu_out", regs[15], 32'hFF);
    exec(16'h1721, 1, "sub_r7");
    check_vec("sub_r7_val", regs[7], 32'hE1);
    exec(16'h65F0, 1, "mov_r5");
    check_vec("mov_alu_op", bus.alu_op, 32'd5);
    check_vec("mov_r5_val", regs[5], 32'hFF);

    // Write to r0 and NOP: no pulse, one retirement each
`ifdef REG_SEQ_PERF_EN
    ret0 = bus.retired;
`endif
    exec(16'h5077, 0, "ldi_r0");
`ifdef REG_SEQ_PERF_EN
    check_vec("ret_ldi_r0", bus.retired, ret0 + 16'd1);
`endif
    exec(16'h7000, 0, "nop");
`ifdef REG_SEQ_PERF_EN
    check_vec("ret_nop", bus.retired, ret0 + 16'd2);
`endif

    // Illegal opcode is sticky across legal instructions
    check_vec("illegal_pre", {31'd0, bus.illegal}, 32'd0);
    exec(16'h9123, 0, "illegal_op");
    check_vec("illegal_set", {31'd0, bus.illegal}, 32'd1);
    exec(16'h5455, 1, "ldi_r4");
    check_vec("illegal_sticky", {31'd0, bus.illegal}, 32'd1);
    check_vec("ldi_r4_val", regs[4], 32'h55);

    // Reset during EXECUTE of ADD r4,r1,r2
    wc0 = write_count;
    bus.instr = 16'h0412;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    check_vec("mid_ra1", bus.RA1, 32'd1);
    nrst = 1'b0;
    #1;
    check_vec("async_ctrl", {bus.RA1, bus.RA2, bus.WA, bus.alu_op, bus.imm}, 32'd0);
    check_vec("async_flags", {bus.write_enable, bus.imm_sel, bus.illegal, bus.halted, bus.instr_ready}, 32'd0);
    repeat (3) step();
    nrst = 1'b1;
    step();
    check_vec("rst_no_write", write_count - wc0, 32'd0);
    check_vec("rst_ready_again", {31'd0, bus.instr_ready}, 32'd1);
    check_vec("illegal_cleared", {31'd0, bus.illegal}, 32'd0);
`ifdef REG_SEQ_PERF_EN
    check_vec("ret_cleared", bus.retired, 32'd0);
`endif

    // HALT then valid held high
    wc0 = write_count;
    bus.instr = 16'hF000;
    bus.instr_valid = 1'b1;
    step();
    bus.instr = 16'h5199;
    step();
    step();
    check_vec("halt_not_yet", {31'd0, bus.halted}, 32'd0);
    step();
    check_vec("halted", {31'd0, bus.halted}, 32'd1);
`ifdef REG_SEQ_PERF_EN
    check_vec("ret_halt", bus.retired, 32'd1);
`endif
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready !== 1'b0) hi_cnt++;
      step();
    end
    bus.instr_valid = 1'b0;
    check_vec("halt_ready_low", hi_cnt, 32'd0);
    check_vec("halt_no_write", write_count - wc0, 32'd0);
    check_vec("halt_stays", {31'd0, bus.halted}, 32'd1);
    check_vec("r1_unchanged", regs[1], 32'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
